// File: rtl/instr_mem_resp.sv
// Instruction memory with a fixed response latency.
// Program load by writes, fetch by reads, one transaction at a time.
module instr_mem_resp #(
  parameter int LATENCY = 3,
  parameter int AW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] wData,
  output logic [15:0] data_out,
  output logic        done,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [3:0] LOAD = 4'(LATENCY - 1);
  localparam int DEPTH = 1 << AW;

  state_t      state;
  state_t      stateNxt;
  logic [3:0]  cnt;
  logic [3:0]  cntNxt;
  logic [AW:0] addrQ;
  logic [15:0] wDataQ;
  logic        rdQ;
  logic        wrQ;
  logic [15:0] holdQ;
  logic        accept;
  logic        bad;
  logic        memWe;
  logic [AW-1:0] idx;
  logic        addrUnused;

  logic [15:0] mem [0:DEPTH-1];

  assign addrUnused = ^addr[15:AW+1];
  assign idx = addrQ[AW:1];
  assign bad = addrQ[0] | (rdQ & wrQ);

  // Next state, counter and response outputs
  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    accept   = 1'b0;
    done     = 1'b0;
    stall    = 1'b0;
    err      = 1'b0;
    memWe    = 1'b0;
    data_out = holdQ;
    unique case (state)
      IDLE: begin
        stateNxt = IDLE;
      end
      BUSY: begin
        stall  = 1'b1;
        cntNxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          stateNxt = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        err      = bad;
        memWe    = wrQ & ~bad;
        data_out = bad ? 16'h0000 : (rdQ ? mem[idx] : holdQ);
        stateNxt = IDLE;
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase
    if (state != BUSY && (rd | wr)) begin
      accept   = 1'b1;
      cntNxt   = LOAD;
      stateNxt = (LATENCY == 1) ? DONE : BUSY;
    end
  end

  // State, counter, request latch and held read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      holdQ  <= '0;
      addrQ  <= '0;
      wDataQ <= '0;
      rdQ    <= 1'b0;
      wrQ    <= 1'b0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
      if (done) begin
        holdQ <= data_out;
      end
      if (accept) begin
        addrQ  <= addr[AW:0];
        wDataQ <= wData;
        rdQ    <= rd;
        wrQ    <= wr;
      end
    end
  end

  // Write commit at the end of the completion cycle; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && memWe) begin
      mem[idx] <= wDataQ;
    end
  end

endmodule
